// File: rtl/uart_reg_ctrl.sv
// UART byte-stream to register-bus bridge: parses write/read request frames,
// drives single-cycle register strobes and streams back ACK or read-data responses.
module uart_reg_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr_ptr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] RESP_HDR  = 8'h5A;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, DATA, WRITE, READ, RWAIT, TX
    } state_t;

    state_t                state;
    logic                  is_write;
    logic [1:0]            byte_cnt;
    logic [2:0]            tx_left;
    logic [DATA_WIDTH-1:0] resp;
    logic [TW-1:0]         idle_cnt;
    logic [ADDR_WIDTH-1:0] addr_byte;
    logic                  timeout_hit;

    // Address byte is zero-extended or truncated to the address width.
    generate
        if (ADDR_WIDTH > 8) begin : g_addr_ext
            assign addr_byte = {{(ADDR_WIDTH-8){1'b0}}, rx_data};
        end else if (ADDR_WIDTH == 8) begin : g_addr_eq
            assign addr_byte = rx_data;
        end else begin : g_addr_trunc
            assign addr_byte = rx_data[ADDR_WIDTH-1:0];
        end
    endgenerate

    assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy        = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            is_write <= 1'b0;
            byte_cnt <= '0;
            tx_left  <= '0;
            resp     <= '0;
            idle_cnt <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            addr_ptr <= '0;
            wdata    <= '0;
            err      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (rx_valid && rx_data == SYNC_BYTE) state <= CMD;
                end
                CMD, ADDR, DATA: begin
                    // An arriving byte wins over a timeout expiring on the same edge.
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        case (state)
                            CMD: begin
                                if (rx_data == CMD_WRITE) begin
                                    is_write <= 1'b1;
                                    state    <= ADDR;
                                end else if (rx_data == CMD_READ) begin
                                    is_write <= 1'b0;
                                    state    <= ADDR;
                                end else begin
                                    err   <= 1'b1;
                                    state <= IDLE;
                                end
                            end
                            ADDR: begin
                                addr_ptr <= addr_byte;
                                byte_cnt <= '0;
                                if (is_write) begin
                                    state <= DATA;
                                end else begin
                                    rd_en <= 1'b1;
                                    state <= READ;
                                end
                            end
                            default: begin
                                wdata    <= {wdata[DATA_WIDTH-9:0], rx_data};
                                byte_cnt <= byte_cnt + 2'd1;
                                if (byte_cnt == 2'd3) begin
                                    wr_en <= 1'b1;
                                    state <= WRITE;
                                end
                            end
                        endcase
                    end else if (timeout_hit) begin
                        idle_cnt <= '0;
                        err      <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                WRITE: begin
                    tx_data  <= ACK_BYTE;
                    tx_valid <= 1'b1;
                    tx_left  <= 3'd0;
                    state    <= TX;
                end
                READ: begin
                    state <= RWAIT;
                end
                RWAIT: begin
                    tx_data  <= RESP_HDR;
                    resp     <= rdata;
                    tx_valid <= 1'b1;
                    tx_left  <= 3'd4;
                    state    <= TX;
                end
                TX: begin
                    if (tx_ready) begin
                        if (tx_left == 3'd0) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data <= resp[DATA_WIDTH-1 -: 8];
                            resp    <= {resp[DATA_WIDTH-9:0], 8'h00};
                            tx_left <= tx_left - 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed bench for uart_reg_ctrl: scoreboard queues hold expected register
// strobes and response bytes; a negedge monitor pops and compares them.
module tb_uart_reg_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  addr_ptr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'h0;
    logic        busy;
    logic        err;

    uart_reg_ctrl #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .tx_valid(tx_valid),
        .tx_data(tx_data),
        .tx_ready(tx_ready),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr_ptr(addr_ptr),
        .wdata(wdata),
        .rdata(rdata),
        .busy(busy),
        .err(err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    logic [7:0]  exp_tx[$];
    logic [39:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic        hold_prev = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    logic [39:0] mon_wr;
    logic [7:0]  mon_b;

    function automatic logic [31:0] reg_model(input logic [7:0] a);
        case (a)
            8'h00:   return 32'h8900_0000;
            8'h01:   return 32'hA1B2_C3D4;
            default: return {4{a}};
        endcase
    endfunction

    // Register file: data appears one clock after the read strobe.
    always @(posedge clock) if (rd_en) rdata <= reg_model(addr_ptr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (wr_en || rd_en) check("wr_rd_exclusive", 64'(wr_en && rd_en), 64'd0);
            if (wr_en) begin
                wr_cnt++;
                check("wr_expected", 64'(exp_wr.size() > 0), 64'd1);
                if (exp_wr.size() > 0) begin
                    mon_wr = exp_wr.pop_front();
                    check("wr_addr_data", {addr_ptr, wdata}, 64'(mon_wr));
                end
            end
            if (rd_en) begin
                rd_cnt++;
                check("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
                if (exp_rd.size() > 0) begin
                    mon_b = exp_rd.pop_front();
                    check("rd_addr", 64'(addr_ptr), 64'(mon_b));
                end
            end
            if (err) err_cnt++;
            if (tx_valid && hold_prev) check("tx_stable", 64'(tx_data), 64'(hold_data));
            if (tx_valid && tx_ready) begin
                check("tx_expected", 64'(exp_tx.size() > 0), 64'd1);
                if (exp_tx.size() > 0) begin
                    mon_b = exp_tx.pop_front();
                    check("tx_byte", 64'(tx_data), 64'(mon_b));
                end
            end
            hold_prev = tx_valid && !tx_ready;
            hold_data = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_read(input logic [7:0] a);
        logic [31:0] d;
        d = reg_model(a);
        exp_rd.push_back(a);
        exp_tx.push_back(8'h5A);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
    endtask

    // Serve the response: each byte sees `hold` cycles of tx_ready=0 before acceptance.
    task automatic run_tx(input int hold);
        int c;
        int phase;
        c = 0;
        phase = 0;
        tx_ready = 1'b0;
        while (c < 400) begin
            @(posedge clock); #1;
            c++;
            if (!busy) break;
            if (tx_ready) begin
                tx_ready = 1'b0;
                phase = 1;
                if (hold == 0) tx_ready = 1'b1;
            end else if (tx_valid) begin
                if (phase >= hold) tx_ready = 1'b1;
                else phase++;
            end
        end
        tx_ready = 1'b0;
        check("tx_completes", 64'(c < 400), 64'd1);
        check("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_wr_rd", 64'({wr_en, rd_en}), 64'd0);
        check("rst_addr", 64'(addr_ptr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        reset = 1'b0;

        // Noise in IDLE
        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (2) @(posedge clock); #1;
        check("noise_no_err", 64'(err_cnt), 64'd0);
        check("noise_idle", 64'(busy), 64'd0);

        // Write frame
        exp_wr.push_back({8'h03, 32'h1234_5678});
        exp_tx.push_back(8'h06);
        send_byte(8'hA5);
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        check("wr_latency", 64'(wr_en), 64'd1);
        run_tx(5);
        check("wr_count", 64'(wr_cnt), 64'd1);
        check("addr_hold", 64'(addr_ptr), 64'h03);
        check("wdata_hold", 64'(wdata), 64'h1234_5678);

        // Read addr 0 with slow tx_ready and bytes arriving during the response
        push_read(8'h00);
        send_byte(8'hA5);
        send_byte(8'h52);
        send_byte(8'h00);
        check("rd_latency", 64'(rd_en), 64'd1);
        fork
            run_tx(3);
            begin
                repeat (2) @(posedge clock);
                send_byte(8'h12);
                send_byte(8'hA5);
                send_byte(8'h52);
                send_byte(8'h00);
            end
        join
        check("rd_count", 64'(rd_cnt), 64'd1);
        check("drop_no_err", 64'(err_cnt), 64'd0);
        check("drop_idle", 64'(busy), 64'd0);

        // Bad command, then a normal read
        send_byte(8'hA5);
        send_byte(8'h33);
        check("badcmd_err_pulse", 64'(err), 64'd1);
        check("badcmd_idle", 64'(busy), 64'd0);
        push_read(8'h01);
        send_byte(8'hA5);
        send_byte(8'h52);
        send_byte(8'h01);
        run_tx(0);
        check("badcmd_err_count", 64'(err_cnt), 64'd1);
        check("badcmd_rd_count", 64'(rd_cnt), 64'd2);

        // Inter-byte timeout mid-write
        send_byte(8'hA5);
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'h11);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (err) begin
                n = i;
                break;
            end
        end
        check("timeout_cycles", 64'(n), 64'd16);
        repeat (2) @(posedge clock); #1;
        check("timeout_err_count", 64'(err_cnt), 64'd2);
        check("timeout_no_wr", 64'(wr_cnt), 64'd1);
        check("timeout_idle", 64'(busy), 64'd0);

        // Reset while the second response byte is pending
        exp_rd.push_back(8'h00);
        exp_tx.push_back(8'h5A);
        send_byte(8'hA5);
        send_byte(8'h52);
        send_byte(8'h00);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) begin
                n = 1;
                break;
            end
            @(posedge clock); #1;
        end
        check("midtx_started", 64'(n), 64'd1);
        tx_ready = 1'b1;
        @(posedge clock); #1;
        tx_ready = 1'b0;
        check("midtx_byte2", 64'(tx_data), 64'h89);
        #2;
        reset = 1'b1;
        #1;
        check("midtx_tx_valid", 64'(tx_valid), 64'd0);
        check("midtx_busy", 64'(busy), 64'd0);
        check("midtx_addr", 64'(addr_ptr), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("midtx_queue", 64'(exp_tx.size()), 64'd0);
        push_read(8'h01);
        send_byte(8'hA5);
        send_byte(8'h52);
        send_byte(8'h01);
        run_tx(1);

        repeat (3) @(posedge clock); #1;
        check("final_wr_count", 64'(wr_cnt), 64'd1);
        check("final_rd_count", 64'(rd_cnt), 64'd4);
        check("final_err_count", 64'(err_cnt), 64'd2);
        check("final_wr_queue", 64'(exp_wr.size()), 64'd0);
        check("final_rd_queue", 64'(exp_rd.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
